// File: rtl/exec_pkg.sv
// Shared opcode encodings, flag bit positions and instruction field layout for the execute unit.
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  // Field layout, LSB first: write_en, load_imm, addr3, addr2, addr1, opcode, imm_b, imm_a
  localparam int OFF_WE = 0;
  localparam int OFF_LI = 1;
  localparam int OFF_A3 = 2;

  function automatic int instr_w(input int dw, input int aw);
    return 2*dw + 4 + 3*aw + 2;
  endfunction

  function automatic int off_a2(input int aw);
    return 2 + aw;
  endfunction

  function automatic int off_a1(input int aw);
    return 2 + 2*aw;
  endfunction

  function automatic int off_op(input int aw);
    return 2 + 3*aw;
  endfunction

  function automatic int off_imm_b(input int aw);
    return 6 + 3*aw;
  endfunction

  function automatic int off_imm_a(input int dw, input int aw);
    return 6 + 3*aw + dw;
  endfunction

  function automatic logic writes_rf(input logic [3:0] op);
    return (op != OP_CMP) && (op < 4'd12);
  endfunction

endpackage

// File: rtl/exec_pipe_if.sv
// Instruction-in / result-out handshake bundle for exec_pipe.
interface exec_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  localparam int INSTR_W = 2*DATA_W + 4 + 3*ADDR_W + 2;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out;
  logic [3:0]         flag;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, out, flag
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, out, flag
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU: (a, b, opcode) -> (result, {carry, zero, sign, overflow}).
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_opcode,
  output logic [DATA_W-1:0] o_out,
  output logic [3:0]        o_flag
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] w_bop;
  logic [SH_W-1:0]   w_sh;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W:0]   w_shl;
  logic [DATA_W:0]   w_shr;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;
  logic              w_nop;

  // INC/DEC reuse the add/subtract paths with a constant one
  assign w_bop  = (i_opcode == OP_INC || i_opcode == OP_DEC) ? DATA_W'(1) : i_b;
  assign w_sh   = i_b[SH_W-1:0];
  assign w_sum  = {1'b0, i_a} + {1'b0, w_bop};
  assign w_diff = {1'b0, i_a} - {1'b0, w_bop};
  // Extra bit catches the last bit shifted out; stays 0 for a zero shift
  assign w_shl  = {1'b0, i_a} << w_sh;
  assign w_shr  = {i_a, 1'b0} >> w_sh;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_nop = 1'b0;
    case (i_opcode)
      OP_ADD, OP_INC: begin
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (i_a[MSB] == w_bop[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        w_res = w_diff[DATA_W-1:0];
        w_c   = w_diff[DATA_W];
        w_v   = (i_a[MSB] != w_bop[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_NOT: w_res = ~i_a;
      OP_SHL: begin
        w_res = w_shl[DATA_W-1:0];
        w_c   = w_shl[DATA_W];
      end
      OP_SHR: begin
        w_res = w_shr[DATA_W:1];
        w_c   = w_shr[0];
      end
      OP_MOV: w_res = i_a;
      default: w_nop = 1'b1;
    endcase

    o_out  = w_res;
    o_flag = '0;
    if (!w_nop) begin
      o_flag[FLAG_C] = w_c;
      o_flag[FLAG_Z] = (w_res == '0);
      o_flag[FLAG_S] = w_res[MSB];
      o_flag[FLAG_V] = w_v;
    end
  end
endmodule

// File: rtl/exec_pipe.sv
// Two-stage execute unit: S1 holds the instruction, S2 holds the ALU result awaiting the consumer.
// Build option FORWARD_EN bypasses the S2 result into S1 operands instead of stalling on a hazard.
module exec_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        rst_n,
  exec_pipe_if.slave io_pipe
);
  localparam int IW    = instr_w(DATA_W, ADDR_W);
  localparam int DEPTH = 2**ADDR_W;
  localparam int O_A2  = off_a2(ADDR_W);
  localparam int O_A1  = off_a1(ADDR_W);
  localparam int O_OP  = off_op(ADDR_W);
  localparam int O_IB  = off_imm_b(ADDR_W);
  localparam int O_IA  = off_imm_a(DATA_W, ADDR_W);

  logic              r_s1_valid;
  logic [IW-1:0]     r_s1_instr;
  logic              r_s2_valid;
  logic              r_s2_we;
  logic [ADDR_W-1:0] r_s2_addr3;
  logic [DATA_W-1:0] r_s2_out;
  logic [3:0]        r_s2_flag;
  logic [DATA_W-1:0] r_rf [DEPTH];

  logic [DATA_W-1:0] w_imm_a, w_imm_b, w_a_reg, w_b_reg, w_a, w_b, w_alu_out;
  logic [ADDR_W-1:0] w_addr1, w_addr2, w_addr3;
  logic [3:0]        w_opcode, w_alu_flag;
  logic              w_load_imm, w_write_en;
  logic              w_hit1, w_hit2, w_stall, w_out_fire, w_s1_adv, w_in_ready;

  assign w_write_en = r_s1_instr[OFF_WE];
  assign w_load_imm = r_s1_instr[OFF_LI];
  assign w_addr3    = r_s1_instr[OFF_A3 +: ADDR_W];
  assign w_addr2    = r_s1_instr[O_A2 +: ADDR_W];
  assign w_addr1    = r_s1_instr[O_A1 +: ADDR_W];
  assign w_opcode   = r_s1_instr[O_OP +: 4];
  assign w_imm_b    = r_s1_instr[O_IB +: DATA_W];
  assign w_imm_a    = r_s1_instr[O_IA +: DATA_W];

  // A register read in S1 that targets the write still pending in S2
  assign w_hit1 = !w_load_imm && r_s2_valid && r_s2_we && (w_addr1 == r_s2_addr3);
  assign w_hit2 = !w_load_imm && r_s2_valid && r_s2_we && (w_addr2 == r_s2_addr3);

`ifdef FORWARD_EN
  // S1 only advances when S2 fires, so the bypassed value is the one being written back
  assign w_stall = 1'b0;
  assign w_a_reg = w_hit1 ? r_s2_out : r_rf[w_addr1];
  assign w_b_reg = w_hit2 ? r_s2_out : r_rf[w_addr2];
`else
  assign w_stall = r_s1_valid && (w_hit1 || w_hit2);
  assign w_a_reg = r_rf[w_addr1];
  assign w_b_reg = r_rf[w_addr2];
`endif

  assign w_a        = w_load_imm ? w_imm_a : w_a_reg;
  assign w_b        = w_load_imm ? w_imm_b : w_b_reg;
  assign w_out_fire = r_s2_valid && io_pipe.out_ready;
  assign w_s1_adv   = r_s1_valid && (!r_s2_valid || w_out_fire) && !w_stall;
  assign w_in_ready = !r_s1_valid || w_s1_adv;

  assign io_pipe.in_ready  = w_in_ready;
  assign io_pipe.out_valid = r_s2_valid;
  assign io_pipe.out       = r_s2_out;
  assign io_pipe.flag      = r_s2_flag;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_opcode (w_opcode),
    .o_out    (w_alu_out),
    .o_flag   (w_alu_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= '0;
    end else if (io_pipe.in_valid && w_in_ready) begin
      r_s1_valid <= 1'b1;
      r_s1_instr <= io_pipe.instr;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_we    <= 1'b0;
      r_s2_addr3 <= '0;
      r_s2_out   <= '0;
      r_s2_flag  <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_we    <= w_write_en && writes_rf(w_opcode);
      r_s2_addr3 <= w_addr3;
      r_s2_out   <= w_alu_out;
      r_s2_flag  <= w_alu_flag;
    end else if (w_out_fire) begin
      r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (w_out_fire && r_s2_we) begin
      r_rf[r_s2_addr3] <= r_s2_out;
    end
  end
endmodule

// File: tb/tb_exec_pipe.sv
// Self-checking bench for exec_pipe: in-order architectural model plus directed literal checks.
module tb_exec_pipe;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int IW = 2*DW + 4 + 3*AW + 2;

  typedef struct {
    int     op;
    int     a1, a2, a3;
    bit     li, we;
    longint ia, ib;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  ins_t   q[$];
  longint mrf[32];
  int     fire_cyc[$];
  longint fire_val[$];
  ins_t   cur;
  longint exp_a, exp_b, exp_r, exp_f;
  bit     prev_hold = 1'b0;

  exec_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  exec_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .io_pipe(bus.slave));

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic logic [IW-1:0] mk(input longint ia, input longint ib, input int op,
                                       input int a1, input int a2, input int a3,
                                       input bit li, input bit we);
    logic [15:0] xa, xb;
    xa = ia[15:0];
    xb = ib[15:0];
    return {xa, xb, 4'(op), 5'(a1), 5'(a2), 5'(a3), li, we};
  endfunction

  function automatic ins_t dec(input logic [IW-1:0] x);
    ins_t d;
    d.we = x[0];
    d.li = x[1];
    d.a3 = int'(x[6:2]);
    d.a2 = int'(x[11:7]);
    d.a1 = int'(x[16:12]);
    d.op = int'(x[20:17]);
    d.ib = longint'(x[36:21]);
    d.ia = longint'(x[52:37]);
    return d;
  endfunction

  // Reference ALU in plain integer arithmetic
  function automatic void model(input longint a, input longint b, input int op,
                                output longint r, output longint f);
    longint m, h, sa, sb, s;
    bit     c, v;
    int     sh;
    m = 65536; h = 32768;
    c = 0; v = 0;
    sh = int'(b % 16);
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    case (op)
      0:      begin s = a + b; r = s % m; c = (s >= m); v = (sa + sb >= h) || (sa + sb < -h); end
      1, 11:  begin r = (a - b + m) % m; c = (a < b); v = (sa - sb >= h) || (sa - sb < -h); end
      2:      r = a & b;
      3:      r = a | b;
      4:      r = a ^ b;
      5:      r = (m - 1) - a;
      6:      begin r = (a << sh) % m; c = (sh != 0) && (((a >> (16 - sh)) & 1) == 1); end
      7:      begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      8:      begin s = a + 1; r = s % m; c = (s >= m); v = (sa + 1 >= h); end
      9:      begin r = (a - 1 + m) % m; c = (a == 0); v = (sa - 1 < -h); end
      10:     r = a;
      default: begin r = 0; f = 0; return; end
    endcase
    f = {c, (r == 0), (r >= h), v};
  endfunction

  // Compare process: inputs/outputs are stable at the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 32; i++) mrf[i] = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("out_valid_held", longint'(bus.out_valid), 1);
      if (bus.out_valid) begin
        chk("out_has_pending_instr", longint'(q.size() != 0), 1);
        if (q.size() != 0) begin
          cur   = q[0];
          exp_a = cur.li ? cur.ia : mrf[cur.a1];
          exp_b = cur.li ? cur.ib : mrf[cur.a2];
          model(exp_a, exp_b, cur.op, exp_r, exp_f);
          chk($sformatf("out_op%0d", cur.op), longint'(bus.out), exp_r);
          chk($sformatf("flag_op%0d", cur.op), longint'(bus.flag), exp_f);
          if (bus.out_ready) begin
            if (cur.we && cur.op < 11) mrf[cur.a3] = exp_r;
            void'(q.pop_front());
            fire_cyc.push_back(cyc);
            fire_val.push_back(longint'(bus.out));
          end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(dec(bus.instr));
      prev_hold = bus.out_valid && !bus.out_ready;
    end
  end

  // All driver tasks start and end at posedge+1
  task automatic send(input logic [IW-1:0] x);
    int n;
    bus.in_valid = 1'b1;
    bus.instr    = x;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output longint o, output longint f, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
    if (!bus.out_valid) chk("result_timeout", 0, 1);
    o = longint'(bus.out);
    f = longint'(bus.flag);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input int r, input string nm, input longint req);
    longint o, f;
    int lat;
    send(mk(0, 0, 10, r, 0, 0, 0, 0));
    get_result(o, f, lat);
    chk(nm, o, req);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint o, f, ho;
    int lat, n, gap_req;
    bit i3_done, rdone;
    longint corners[5];
    corners[0] = 0; corners[1] = 1; corners[2] = 'h7FFF; corners[3] = 'h8000; corners[4] = 'hFFFF;

    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_out", longint'(bus.out), 0);
    chk("reset_flag", longint'(bus.flag), 0);
    chk("reset_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Immediate ADD with writeback, minimum latency
    send(mk('h2, 'h1, 0, 0, 0, 2, 1, 1));
    get_result(o, f, lat);
    chk("t1_out", o, 'h3);
    chk("t1_flag", f, 'b0000);
    chk("t1_latency", lat, 2);
    read_reg(2, "t1_rf2", 'h3);

    // Carry/zero wrap and signed overflow on subtract
    send(mk('hFFFF, 'h1, 0, 0, 0, 0, 1, 0));
    get_result(o, f, lat);
    chk("t2_add_out", o, 'h0);
    chk("t2_add_flag", f, 'b1100);
    send(mk('h8000, 'h1, 1, 0, 0, 0, 1, 0));
    get_result(o, f, lat);
    chk("t2_sub_out", o, 'h7FFF);
    chk("t2_sub_flag", f, 'b0001);

    // Dependent back-to-back pair
    fire_cyc.delete();
    fire_val.delete();
    send(mk('h5, 'h0, 0, 0, 0, 1, 1, 1));
    send(mk('h0, 'h0, 0, 1, 1, 0, 0, 0));
    n = 0;
    while (fire_cyc.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_fires", fire_cyc.size(), 2);
    if (fire_cyc.size() >= 2) begin
`ifdef FORWARD_EN
      gap_req = 1;
`else
      gap_req = 2;
`endif
      chk("t3_gap", fire_cyc[1] - fire_cyc[0], gap_req);
      chk("t3_out", fire_val[1], 'hA);
    end
    @(posedge clk);
    #1;

    // Backpressure with three instructions queued
    bus.out_ready = 1'b0;
    send(mk('h10, 'h20, 0, 0, 0, 7, 1, 1));
    send(mk('h0, 'h0, 0, 7, 7, 8, 0, 1));
    i3_done = 1'b0;
    fork
      begin
        send(mk('hF0F0, 'h0FF0, 4, 0, 0, 9, 1, 1));
        i3_done = 1'b1;
      end
    join_none
    @(negedge clk);
    ho = longint'(bus.out);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_in_ready_low", longint'(bus.in_ready), 0);
      chk("t4_out_stable", longint'(bus.out), ho);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    n = 0;
    while (!i3_done && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("t4_third_accepted", longint'(i3_done), 1);
    #1;
    drain();
    read_reg(7, "t4_rf7", 'h30);
    read_reg(8, "t4_rf8", 'h60);
    read_reg(9, "t4_rf9", 'hFF00);

    // CMP and NOP never write
    send(mk('h1234, 'h0, 10, 0, 0, 4, 1, 1));
    get_result(o, f, lat);
    send(mk('h3, 'h3, 11, 0, 0, 4, 1, 1));
    get_result(o, f, lat);
    chk("t5_cmp_out", o, 'h0);
    chk("t5_cmp_flag", f, 'b0100);
    read_reg(4, "t5_rf4_after_cmp", 'h1234);
    send(mk('h5, 'h6, 14, 0, 0, 4, 1, 1));
    get_result(o, f, lat);
    chk("t5_nop_out", o, 'h0);
    chk("t5_nop_flag", f, 'b0000);
    read_reg(4, "t5_rf4_after_nop", 'h1234);

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(mk('h55, 'h0, 0, 0, 0, 9, 1, 1));
    send(mk('h1, 'h1, 0, 0, 0, 10, 1, 1));
    @(negedge clk);
    chk("t6_full_before_reset", longint'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", longint'(bus.out_valid), 0);
    chk("t6_rst_out", longint'(bus.out), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("t6_in_ready_after", longint'(bus.in_ready), 1);
    read_reg(9, "t6_rf9", 'h0);
    read_reg(10, "t6_rf10", 'h0);
    read_reg(4, "t6_rf4", 'h0);

    // Randomized traffic with random backpressure and dense hazards
    rdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          longint ia, ib;
          ia = ($urandom % 4 == 0) ? corners[$urandom % 5] : longint'($urandom % 65536);
          ib = ($urandom % 4 == 0) ? corners[$urandom % 5] : longint'($urandom % 65536);
          send(mk(ia, ib, int'($urandom % 16), int'($urandom % 4), int'($urandom % 4),
                  int'($urandom % 4), bit'($urandom % 2), ($urandom % 4) != 0));
          repeat ($urandom % 3) begin
            @(posedge clk);
            #1;
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom % 4) != 0;
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    for (int r = 0; r < 32; r++) begin
      send(mk(0, 0, 10, r, 0, 0, 0, 0));
      get_result(o, f, lat);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
